// File: rtl/t02_mem_arb_pkg.sv
// Shared types for the t02 memory arbiter: sequencer states, grant owner and bus op.
package t02_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  function automatic grant_t other_port(input grant_t g);
    return (g == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/t02_arb_watchdog.sv
// Bus-hang watchdog: down-counter reloaded while idle, decremented while a
// transaction is outstanding, expiring on the TIMEOUT_CYCLES-th running cycle.
module t02_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt;

  // Reload on clear so the first running cycle sees TIMEOUT_CYCLES-1 remaining
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/t02_mem_arbiter.sv
// Arbiter sharing the wishbone manager port between instruction fetch and data access.
//
// state | meaning
// IDLE  | waiting for en, a free manager and a pending request
// ISSUE | READ/WRITE strobe to manager until it reports busy
// WAIT  | strobe dropped, address/data held until manager goes idle
// RESP  | one cycle: granted port's busy drops, read data already captured
module t02_mem_arbiter
  import t02_mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_busy,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_busy,
  output logic              m_ren,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_busy,
  output logic              bus_err
);

  state_t            state;
  grant_t            grant;
  grant_t            prio;
  grant_t            pick;
  op_t               op;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              m_ren_q;
  logic              m_wen_q;
  logic              bus_err_q;
  logic              i_req;
  logic              d_req;
  logic              start;
  logic              finish;
  logic              wd_run;
  logic              wd_expired;
  logic [DATA_W-1:0] resp_data;

  assign i_req  = i_ren;
  assign d_req  = d_ren | d_wen;
  assign start  = en && !m_busy && (i_req || d_req);
  assign wd_run = (state == ISSUE) || (state == WAIT);
  assign finish = ((state == ISSUE) && wd_expired) ||
                  ((state == WAIT) && (wd_expired || !m_busy));
  assign resp_data = wd_expired ? ERR_DATA : m_rdata;

  t02_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (!wd_run),
    .run    (wd_run),
    .expired(wd_expired)
  );

  // Lone requester wins; with both pending the preferred port (data out of reset) wins
  always_comb begin
    pick = prio;
    if (i_req && !d_req) begin
      pick = GRANT_I;
    end else if (d_req && !i_req) begin
      pick = GRANT_D;
    end
  end

  // Sequencer: grant and latch, bus handshake, timeout abort and read-data capture
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      grant     <= GRANT_D;
      prio      <= GRANT_D;
      op        <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_ren_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            grant <= pick;
            prio  <= other_port(pick);
            if (pick == GRANT_I) begin
              addr_q  <= i_addr;
              op      <= OP_RD;
              m_ren_q <= 1'b1;
            end else begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              op      <= d_wen ? OP_WR : OP_RD;
              m_ren_q <= !d_wen;
              m_wen_q <= d_wen;
            end
          end
        end
        ISSUE: begin
          if (wd_expired || m_busy) begin
            state   <= wd_expired ? RESP : WAIT;
            m_ren_q <= 1'b0;
            m_wen_q <= 1'b0;
          end
        end
        WAIT: begin
          if (wd_expired || !m_busy) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (finish) begin
        if (wd_expired) begin
          bus_err_q <= 1'b1;
        end
        // A requester that has already let go gets nothing back
        if (op == OP_RD) begin
          if ((grant == GRANT_I) && i_req) begin
            i_rdata_q <= resp_data;
          end
          if ((grant == GRANT_D) && d_ren) begin
            d_rdata_q <= resp_data;
          end
        end
      end
    end
  end

  assign i_busy  = i_req && !((state == RESP) && (grant == GRANT_I));
  assign d_busy  = d_req && !((state == RESP) && (grant == GRANT_D));
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_ren   = m_ren_q;
  assign m_wen   = m_wen_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Bench for t02_mem_arbiter: a behavioural manager with programmable latency,
// plus a transaction-level model of grant order, latency and returned data.
module tb_t02_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        i_ren, d_ren, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_busy, d_busy;
  logic        m_ren, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        m_busy = 1'b0;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  t02_mem_arbiter #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .en     (en),
    .i_ren  (i_ren),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_busy (i_busy),
    .d_ren  (d_ren),
    .d_wen  (d_wen),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_busy (d_busy),
    .m_ren  (m_ren),
    .m_wen  (m_wen),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_busy (m_busy),
    .bus_err(bus_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Manager: accepts a strobe when idle, stays busy for a queued latency (or forever when hung)
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] slv_mem[logic [31:0]];
  txn_t        log_q[$];
  int          lat_q[$];
  bit          hung = 0;
  int          mgr_cnt = 0;
  txn_t        mt;

  always @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy  = 1'b0;
      mgr_cnt = 0;
    end else if (m_busy) begin
      if (!hung) begin
        if (mgr_cnt <= 1) m_busy = 1'b0;
        else mgr_cnt--;
      end
    end else if (m_ren || m_wen) begin
      mt.wr    = m_wen;
      mt.addr  = m_addr;
      mt.wdata = m_wdata;
      log_q.push_back(mt);
      if (m_wen) slv_mem[m_addr] = m_wdata;
      else m_rdata = slv_mem.exists(m_addr) ? slv_mem[m_addr] : dflt(m_addr);
      mgr_cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      m_busy  = 1'b1;
    end
  end

  // Reference model state: memory image, preferred port, expected held read data
  logic [31:0] ref_mem[logic [31:0]];
  bit          tok_d = 1;
  logic [31:0] exp_i = 32'h0;
  logic [31:0] exp_d = 32'h0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // One round: raise the chosen requests together, drop each as its busy falls
  task automatic run_scn(input string nm, input bit ri, input bit rd, input bit wd,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wdat, input int la, input int lb);
    bit dq, first_d, i_done, d_done;
    int t, t_i, t_d;
    bit ord[$];
    txn_t g;
    dq      = rd | wd;
    first_d = dq && (!ri || tok_d);
    if (first_d) begin
      ord.push_back(1'b1);
      if (ri) ord.push_back(1'b0);
    end else begin
      ord.push_back(1'b0);
      if (dq) ord.push_back(1'b1);
    end
    if (ri && dq) tok_d = first_d;
    else tok_d = !dq;
    lat_q.push_back(la);
    if (ord.size() > 1) lat_q.push_back(lb);
    t_i = 0;
    t_d = 0;

    @(negedge clk);
    i_ren   = ri;
    i_addr  = ia;
    d_ren   = rd;
    d_wen   = wd;
    d_addr  = da;
    d_wdata = wdat;
    i_done  = !ri;
    d_done  = !dq;
    t       = 0;
    while (!(i_done && d_done) && (t < 200)) begin
      @(negedge clk);
      t++;
      if (!i_done && !i_busy) begin
        i_done = 1;
        t_i    = t;
        i_ren  = 1'b0;
      end
      if (!d_done && !d_busy) begin
        d_done = 1;
        t_d    = t;
        d_ren  = 1'b0;
        d_wen  = 1'b0;
      end
    end
    check_val({nm, "_done"}, {30'd0, i_done, d_done}, 32'd3);
    check_val({nm, "_ntxn"}, log_q.size(), ord.size());

    for (int k = 0; k < ord.size(); k++) begin
      int exp_t;
      exp_t = (k == 0) ? (2 + la) : (5 + la + lb);
      if (log_q.size() > 0) begin
        g = log_q.pop_front();
        if (ord[k]) begin
          check_val({nm, "_d_op"}, {31'd0, g.wr}, {31'd0, wd});
          check_val({nm, "_d_addr"}, g.addr, da);
          check_val({nm, "_d_lat"}, t_d, exp_t);
          if (wd) begin
            check_val({nm, "_d_wdata"}, g.wdata, wdat);
            ref_mem[da] = wdat;
          end else begin
            exp_d = ref_rd(da);
          end
        end else begin
          check_val({nm, "_i_op"}, {31'd0, g.wr}, 32'd0);
          check_val({nm, "_i_addr"}, g.addr, ia);
          check_val({nm, "_i_lat"}, t_i, exp_t);
          exp_i = ref_rd(ia);
        end
      end
    end
    check_val({nm, "_i_rdata"}, i_rdata, exp_i);
    check_val({nm, "_d_rdata"}, d_rdata, exp_d);
  endtask

  initial begin
    int t, viol, dk;
    bit ri;
    txn_t g;

    slv_mem[32'h40] = 32'h1234_5678;
    ref_mem[32'h40] = 32'h1234_5678;
    nrst = 1'b0; en = 1'b1;
    i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check_val("rst_m_strobe", {30'd0, m_ren, m_wen}, 32'd0);
    check_val("rst_m_addr", m_addr, 32'd0);
    check_val("rst_m_wdata", m_wdata, 32'd0);
    check_val("rst_rdata", i_rdata | d_rdata, 32'd0);
    check_val("rst_flags", {29'd0, i_busy, d_busy, bus_err}, 32'd0);
    nrst = 1'b1;

    run_scn("both_rst", 1, 0, 1, 32'h80, 32'h80, 32'h0BAD_F00D, 1, 1);
    run_scn("fetch", 1, 0, 0, 32'h40, 32'h0, 32'h0, 1, 1);
    run_scn("store", 0, 0, 1, 32'h0, 32'h100, 32'hCAFE_F00D, 1, 1);
    for (int n = 0; n < 3; n++) begin
      run_scn("dbl", 1, 1, 0, 32'h40, 32'h100, 32'h0, 1, 2);
    end

    for (int n = 0; n < 16; n++) begin
      ri = 1'($urandom_range(0, 1));
      dk = $urandom_range(0, 3);
      if (!ri && dk == 0) ri = 1;
      run_scn("rnd", ri, (dk == 1) || (dk == 3), (dk >= 2),
              32'($urandom_range(0, 7)) << 6, 32'($urandom_range(0, 7)) << 6,
              $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
    end

    // en low holds off the grant; raising it lets the fetch run normally
    en = 1'b0;
    lat_q.push_back(2);
    @(negedge clk);
    i_ren  = 1'b1;
    i_addr = 32'h140;
    viol   = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_ren || !i_busy) viol++;
    end
    check_val("en_hold", viol, 0);
    en = 1'b1;
    t  = 0;
    while (t < 50) begin
      @(negedge clk);
      t++;
      if (!i_busy) break;
    end
    i_ren = 1'b0;
    check_val("en_lat", t, 4);
    exp_i = ref_rd(32'h140);
    tok_d = 1;
    check_val("en_rdata", i_rdata, exp_i);
    check_val("en_ntxn", log_q.size(), 1);
    if (log_q.size() > 0) begin
      g = log_q.pop_front();
      check_val("en_addr", g.addr, 32'h140);
    end

    // Hung manager: watchdog aborts the data read with the error word
    hung = 1;
    @(negedge clk);
    d_ren  = 1'b1;
    d_addr = 32'h180;
    t      = 0;
    while (t < 100) begin
      @(negedge clk);
      t++;
      if (!d_busy) break;
    end
    d_ren = 1'b0;
    check_val("hang_lat", t, TO + 1);
    check_val("hang_err", {31'd0, bus_err}, 32'd1);
    exp_d = 32'hDEAD_BEEF;
    tok_d = 0;
    check_val("hang_rdata", d_rdata, exp_d);
    log_q.delete();

    @(negedge clk);
    i_ren  = 1'b1;
    i_addr = 32'h40;
    viol   = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_ren || !i_busy) viol++;
    end
    check_val("hang_no_grant", viol, 0);
    hung = 0;
    lat_q.push_back(1);
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      t++;
      if (!i_busy) break;
    end
    i_ren = 1'b0;
    exp_i = ref_rd(32'h40);
    tok_d = 1;
    check_val("hang_recover_done", {31'd0, i_busy}, 32'd0);
    check_val("hang_recover_rdata", i_rdata, exp_i);
    check_val("hang_err_sticky", {31'd0, bus_err}, 32'd1);
    log_q.delete();

    // Reset asserted while the manager is still busy
    lat_q.push_back(6);
    @(negedge clk);
    d_ren  = 1'b1;
    d_addr = 32'h1C0;
    repeat (3) @(negedge clk);
    nrst  = 1'b0;
    d_ren = 1'b0;
    #1;
    check_val("midrst_m_strobe", {30'd0, m_ren, m_wen}, 32'd0);
    check_val("midrst_m_addr", m_addr, 32'd0);
    check_val("midrst_rdata", i_rdata | d_rdata, 32'd0);
    check_val("midrst_flags", {29'd0, i_busy, d_busy, bus_err}, 32'd0);
    log_q.delete();
    lat_q.delete();
    @(negedge clk);
    @(negedge clk);
    nrst  = 1'b1;
    tok_d = 1;
    exp_i = 32'h0;
    exp_d = 32'h0;
    run_scn("post_rst", 0, 1, 0, 32'h0, 32'h80, 32'h0, 2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
